// File: rtl/clkgt_pkg.sv
// Shared types and constants for the multi-channel clock-gating controller.
package clkgt_pkg;

  typedef enum logic [1:0] {CG_ON, CG_HOLD, CG_OFF} cg_state_t;

  localparam int PERF_W = 32;

  // Saturating increment for the off-cycle performance counters.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/clkgt_cell.sv
// Latch-based integrated clock gate: enable is captured while ck is low,
// so q only ever carries whole ck high phases.
module clkgt_cell (
  input  logic te,
  input  logic e,
  input  logic ck,
  output logic q
);

  logic en_lat;

  always_latch begin
    if (!ck) en_lat <= e | te;
  end

  assign q = ck & en_lat;

endmodule

// File: rtl/multi_clkgt_ctrl.sv
// Multi-channel clock-gating controller: per-channel ON/HOLD/OFF idle-hold FSM
// driving one ICG each. Optional off-cycle counters under CLKGT_PERF_EN.
module multi_clkgt_ctrl
  import clkgt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int HOLD_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     te,
  input  logic                     force_on,
  input  logic [NUM_CH-1:0]        en_req,
  input  logic [NUM_CH*HOLD_W-1:0] hold_cfg,
  output logic [NUM_CH-1:0]        gck,
`ifdef CLKGT_PERF_EN
  input  logic                     perf_clr,
  output logic [NUM_CH*PERF_W-1:0] off_cnt,
`endif
  output logic [NUM_CH-1:0]        clk_on
);

  localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
    cg_state_t         state_reg;
    logic [HOLD_W-1:0] cnt_reg;
    logic              clk_on_reg;
    logic [HOLD_W-1:0] hold_val;
    logic              gate_e;

    assign hold_val = hold_cfg[gi*HOLD_W +: HOLD_W];

    // Reset lands in ON so downstream synchronous resets keep seeing edges.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_reg  <= CG_ON;
        cnt_reg    <= '0;
        clk_on_reg <= 1'b1;
      end else begin
        unique case (state_reg)
          CG_ON: begin
            if (!en_req[gi]) begin
              if (hold_val != '0) begin
                state_reg <= CG_HOLD;
                cnt_reg   <= hold_val;
              end else begin
                state_reg  <= CG_OFF;
                clk_on_reg <= 1'b0;
              end
            end
          end
          CG_HOLD: begin
            // A fresh request beats expiry on the same edge.
            if (en_req[gi]) begin
              state_reg <= CG_ON;
            end else if (cnt_reg == CNT_ONE) begin
              state_reg  <= CG_OFF;
              clk_on_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
          CG_OFF: begin
            if (en_req[gi]) begin
              state_reg  <= CG_ON;
              clk_on_reg <= 1'b1;
            end
          end
          default: begin
            state_reg  <= CG_ON;
            clk_on_reg <= 1'b1;
          end
        endcase
      end
    end

    assign gate_e     = (state_reg != CG_OFF) | force_on;
    assign clk_on[gi] = clk_on_reg;

    clkgt_cell u_cell (
      .te (te),
      .e  (gate_e),
      .ck (clock),
      .q  (gck[gi])
    );

`ifdef CLKGT_PERF_EN
    logic [PERF_W-1:0] off_cnt_reg;

    // Counts only genuinely stopped cycles; forced-open cycles are excluded.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        off_cnt_reg <= '0;
      end else if (perf_clr) begin
        off_cnt_reg <= '0;
      end else if (state_reg == CG_OFF && !force_on && !te) begin
        off_cnt_reg <= sat_inc(off_cnt_reg);
      end
    end

    assign off_cnt[gi*PERF_W +: PERF_W] = off_cnt_reg;
`endif
  end

endmodule

// File: tb/tb_multi_clkgt_ctrl.sv
// Bench for multi_clkgt_ctrl: per-cycle vector table with scoreboard, plus
// hand sequences for runt-free te changes, async reset mid-HOLD and perf counters.
module tb_multi_clkgt_ctrl;
  import clkgt_pkg::*;

  localparam int NUM_CH = 4;
  localparam int HOLD_W = 4;
  localparam logic [15:0] H0 = 16'h1503; // ch3=1 ch2=5 ch1=0 ch0=3
  localparam logic [15:0] H1 = 16'h1203; // ch2 hold changed to 2

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        te = 1'b0;
  logic        force_on = 1'b0;
  logic [3:0]  en_req = 4'b0;
  logic [15:0] hold_cfg = H0;
  logic [3:0]  gck;
  logic [3:0]  clk_on;
`ifdef CLKGT_PERF_EN
  logic         perf_clr = 1'b0;
  logic [127:0] off_cnt;
`endif

  multi_clkgt_ctrl #(.NUM_CH(NUM_CH), .HOLD_W(HOLD_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .te       (te),
    .force_on (force_on),
    .en_req   (en_req),
    .hold_cfg (hold_cfg),
    .gck      (gck),
`ifdef CLKGT_PERF_EN
    .perf_clr (perf_clr),
    .off_cnt  (off_cnt),
`endif
    .clk_on   (clk_on)
  );

  always #5 clock = ~clock;

  // Rising-edge counters on each gated clock.
  int unsigned ec0 = 0, ec1 = 0, ec2 = 0, ec3 = 0;
  always @(posedge gck[0]) ec0++;
  always @(posedge gck[1]) ec1++;
  always @(posedge gck[2]) ec2++;
  always @(posedge gck[3]) ec3++;

  function automatic int unsigned ec(input int i);
    case (i)
      0: return ec0;
      1: return ec1;
      2: return ec2;
      default: return ec3;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  en;
    logic [15:0] hold;
    logic        te;
    logic        fo;
    logic [3:0]  exp_pulse;
    logic [3:0]  exp_on;
  } vec_t;

  typedef struct {
    logic [3:0] pulse;
    logic [3:0] on;
    int         idx;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [3:0] en, input logic [15:0] hold, input logic t,
                              input logic fo, input logic [3:0] p, input logic [3:0] o);
    vec_t v;
    v.en = en; v.hold = hold; v.te = t; v.fo = fo; v.exp_pulse = p; v.exp_on = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector at a negedge; pulses of the next posedge and the new
  // clk_on are checked at the following negedge.
  task automatic apply(input int i);
    int unsigned snap [4];
    logic [3:0]  mask;
    exp_t        e;
    en_req   = vt[i].en;
    hold_cfg = vt[i].hold;
    te       = vt[i].te;
    force_on = vt[i].fo;
    for (int k = 0; k < 4; k++) snap[k] = ec(k);
    sb.push_back('{pulse: vt[i].exp_pulse, on: vt[i].exp_on, idx: i});
    @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 4; k++) mask[k] = ((ec(k) - snap[k]) != 0);
    e = sb.pop_front();
    check($sformatf("pulse_v%0d", e.idx), {28'b0, mask}, {28'b0, e.pulse});
    check($sformatf("clk_on_v%0d", e.idx), {28'b0, clk_on}, {28'b0, e.on});
    $display("vec %0d en=%b hold=%h te=%b fo=%b pulse=%b clk_on=%b",
             e.idx, vt[i].en, vt[i].hold, vt[i].te, vt[i].fo, mask, clk_on);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned snap [4];

    // en, hold, te, fo, expected pulses at next edge, expected clk_on after it
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b1111, 4'b1101)); // 0 leave ON
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b1101, 4'b0101)); // 1 ch3 hold=1 expires
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0101, 4'b0101));
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0101, 4'b0100)); // 3 ch0 third extra pulse, OFF
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0100, 4'b0100));
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0100, 4'b0000)); // 5 ch2 fifth extra pulse, OFF
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0000, 4'b0000));
    vt.push_back(mk(4'b0010, H0, 0, 0, 4'b0000, 4'b0010)); // 7 one-cycle request, hold 0
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0010, 4'b0000));
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0000, 4'b0000));
    vt.push_back(mk(4'b0000, H0, 1, 0, 4'b1111, 4'b0000)); // 10 te opens all gates
    vt.push_back(mk(4'b0000, H0, 1, 0, 4'b1111, 4'b0000));
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0000, 4'b0000));
    vt.push_back(mk(4'b0000, H0, 0, 1, 4'b1111, 4'b0000)); // 13 force_on
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0000, 4'b0000));
    vt.push_back(mk(4'b1000, H0, 0, 0, 4'b0000, 4'b1000)); // 15 ch3 on
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b1000, 4'b1000)); // ch3 HOLD cnt=1
    vt.push_back(mk(4'b1000, H0, 0, 0, 4'b1000, 4'b1000)); // 17 request beats expiry
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b1000, 4'b1000));
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b1000, 4'b0000));
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0000, 4'b0000));
    vt.push_back(mk(4'b0100, H0, 0, 0, 4'b0000, 4'b0100)); // 21 ch2 on
    vt.push_back(mk(4'b0000, H0, 0, 0, 4'b0100, 4'b0100)); // HOLD with 5
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0100, 4'b0100)); // 23 hold_cfg -> 2 mid-HOLD
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0100, 4'b0100));
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0100, 4'b0100));
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0100, 4'b0100));
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0100, 4'b0000)); // 27 fifth extra pulse, OFF
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0000, 4'b0000));
    vt.push_back(mk(4'b0100, H1, 0, 0, 4'b0000, 4'b0100)); // 29 ch2 on again
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0100, 4'b0100)); // HOLD with 2
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0100, 4'b0100));
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0100, 4'b0000)); // 32 second extra pulse, OFF
    vt.push_back(mk(4'b0000, H1, 0, 0, 4'b0000, 4'b0000));

    // Reset: gates open and clk_on all ones while reset is held.
    #1 reset = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 4; k++) snap[k] = ec(k);
    repeat (3) @(negedge clock);
    for (int k = 0; k < 4; k++) check($sformatf("rst_pulses_ch%0d", k), ec(k) - snap[k], 32'd3);
    check("rst_clk_on", {28'b0, clk_on}, 32'hF);

    reset = 1'b0;
    for (int i = 0; i < vt.size(); i++) apply(i);

    // te raised and dropped during clock high: no runt, no truncation.
    @(posedge clock);
    #2 te = 1'b1;
    #1 check("te_rise_high", {28'b0, gck}, 32'h0);
    @(posedge clock);
    #1 check("te_open", {28'b0, gck}, 32'hF);
    #1 te = 1'b0;
    #1 check("te_drop_high", {28'b0, gck}, 32'hF);
    @(posedge clock);
    #1 check("te_closed", {28'b0, gck}, 32'h0);
    check("te_clk_on", {28'b0, clk_on}, 32'h0);
    $display("seq te_runt done");

    // Async reset asserted while ch0 is in HOLD, during clock high.
    @(negedge clock);
    en_req = 4'b0001;
    @(posedge clock);
    @(negedge clock);
    en_req = 4'b0000;
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check("arst_clk_on", {28'b0, clk_on}, 32'hF);
    check("arst_gck_high", {28'b0, gck}, 32'h1);
    @(posedge clock);
    #1 check("arst_gate_open", {28'b0, gck}, 32'hF);
    $display("seq async_reset done");

    @(negedge clock);
    reset = 1'b0;
`ifdef CLKGT_PERF_EN
    perf_clr = 1'b1;
    @(posedge clock);
    @(negedge clock);
    perf_clr = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("off_cnt_10", off_cnt[63:32], 32'd10);
    perf_clr = 1'b1;
    @(posedge clock);
    @(negedge clock);
    perf_clr = 1'b0;
    check("off_cnt_clr", off_cnt[63:32], 32'd0);
    $display("seq perf done");
`endif
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
